// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU operation sequencer: state encoding,
// display letter codes and the default WAIT timeout.
package alu_ctrl_pkg;

    // Maximum number of WAIT cycles allowed for alu_done.
    localparam int unsigned TimeoutDefault = 16;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StHaveA = 3'd1,
        StHaveB = 3'd2,
        StWait  = 3'd3,
        StShow  = 3'd4,
        StErr   = 3'd5
    } state_e;

    localparam logic [3:0] LetterIdle  = 4'hF;
    localparam logic [3:0] LetterHaveA = 4'hA;
    localparam logic [3:0] LetterHaveB = 4'hB;
    localparam logic [3:0] LetterWait  = 4'hD;
    localparam logic [3:0] LetterShow  = 4'hC;
    localparam logic [3:0] LetterErr   = 4'hE;

    // Display letter for a given state.
    function automatic logic [3:0] state_letter(input state_e st);
        logic [3:0] code;
        unique case (st)
            StIdle:  code = LetterIdle;
            StHaveA: code = LetterHaveA;
            StHaveB: code = LetterHaveB;
            StWait:  code = LetterWait;
            StShow:  code = LetterShow;
            StErr:   code = LetterErr;
            default: code = LetterIdle;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/pb_edge_detect.sv
// Rising-edge detector for a debounced push-button level.
// The previous-level register resets to 1 so a button held through reset
// produces no press until it is released and pressed again.
module pb_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic press
);

    logic prev_q;

    // Track the previous button level.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign press = level & ~prev_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Push-button driven sequencer: captures operands A/B and an opcode from the
// switches, starts an external ALU, waits (with timeout) for its result and
// shows it on the LEDs.
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       pb_a,
    input  logic       pb_b,
    input  logic       pb_op,
    input  logic [7:0] sw,
    input  logic       alu_done,
    input  logic [8:0] alu_result,
    output logic [7:0] A_out,
    output logic [7:0] B_out,
    output logic [1:0] op_out,
    output logic       alu_start,
    output logic [8:0] Out_with_carry,
    output logic       result_valid,
    output logic [3:0] Letters,
    output logic [7:0] LED
);

    // Counter value of the last WAIT cycle in which alu_done is still accepted.
    localparam logic [3:0] CntLast = 4'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] a_q, b_q;
    logic [1:0] op_q;
    logic [8:0] res_q;
    logic       start_q;

    logic press_a, press_b, press_op;
    logic cap_a, cap_b, cap_op, cap_res, clr_res, go;

    pb_edge_detect u_edge_a (
        .clk   (Clk),
        .rst   (Reset),
        .level (pb_a),
        .press (press_a)
    );

    pb_edge_detect u_edge_b (
        .clk   (Clk),
        .rst   (Reset),
        .level (pb_b),
        .press (press_b)
    );

    pb_edge_detect u_edge_op (
        .clk   (Clk),
        .rst   (Reset),
        .level (pb_op),
        .press (press_op)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath load strobes; presses resolve as op > b > a.
    always_comb begin
        state_d = state_q;
        cap_a   = 1'b0;
        cap_b   = 1'b0;
        cap_op  = 1'b0;
        cap_res = 1'b0;
        clr_res = 1'b0;
        go      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (press_a) begin
                    cap_a   = 1'b1;
                    state_d = StHaveA;
                end
            end
            StHaveA: begin
                if (press_b) begin
                    cap_b   = 1'b1;
                    state_d = StHaveB;
                end else if (press_a) begin
                    cap_a = 1'b1;
                end
            end
            StHaveB: begin
                if (press_op) begin
                    cap_op  = 1'b1;
                    go      = 1'b1;
                    state_d = StWait;
                end else if (press_b) begin
                    cap_b = 1'b1;
                end else if (press_a) begin
                    cap_a   = 1'b1;
                    state_d = StHaveA;
                end
            end
            StWait: begin
                if (alu_done) begin
                    cap_res = 1'b1;
                    state_d = StShow;
                end else if (cnt_q == CntLast) begin
                    clr_res = 1'b1;
                    state_d = StErr;
                end
            end
            StShow: begin
                if (press_op) begin
                    cap_op  = 1'b1;
                    go      = 1'b1;
                    state_d = StWait;
                end else if (press_a) begin
                    cap_a   = 1'b1;
                    state_d = StHaveA;
                end
            end
            StErr: begin
                if (press_a) begin
                    cap_a   = 1'b1;
                    state_d = StHaveA;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // WAIT cycle counter; held at zero outside WAIT so every entry starts fresh.
    always_comb begin
        cnt_d = '0;
        if (state_q == StWait) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Operand, opcode, result and start-pulse registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            start_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (cap_a) begin
                a_q <= sw;
            end
            if (cap_b) begin
                b_q <= sw;
            end
            if (cap_op) begin
                op_q <= sw[1:0];
            end
            if (cap_res) begin
                res_q <= alu_result;
            end else if (clr_res) begin
                res_q <= '0;
            end
            // WAIT always lasts at least one cycle, so the pulse cannot repeat back to back.
            start_q <= go;
            cnt_q   <= cnt_d;
        end
    end

    // Display and status outputs decoded from the current state.
    always_comb begin
        Letters      = state_letter(state_q);
        result_valid = (state_q == StShow);
        LED          = 8'h00;
        unique case (state_q)
            StIdle:  LED = sw;
            StHaveA: LED = a_q;
            StHaveB: LED = b_q;
            StWait:  LED = 8'h00;
            StShow:  LED = res_q[7:0];
            StErr:   LED = 8'hFF;
            default: LED = 8'h00;
        endcase
    end

    assign A_out          = a_q;
    assign B_out          = b_q;
    assign op_out         = op_q;
    assign alu_start      = start_q;
    assign Out_with_carry = res_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: expected start transactions and
// results are queued when stimulus is driven and compared when the DUT emits them.
module tb_alu_op_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       pb_a, pb_b, pb_op;
    logic [7:0] sw;
    logic       alu_done;
    logic [8:0] alu_result;
    logic [7:0] A_out, B_out;
    logic [1:0] op_out;
    logic       alu_start;
    logic [8:0] Out_with_carry;
    logic       result_valid;
    logic [3:0] Letters;
    logic [7:0] LED;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } start_exp_t;

    start_exp_t start_q[$];
    logic [8:0] res_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int start_count = 0;
    int cnt0;
    logic start_prev = 1'b0;
    logic rv_prev = 1'b0;

    alu_op_sequencer #(
        .TIMEOUT (16)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .pb_a           (pb_a),
        .pb_b           (pb_b),
        .pb_op          (pb_op),
        .sw             (sw),
        .alu_done       (alu_done),
        .alu_result     (alu_result),
        .A_out          (A_out),
        .B_out          (B_out),
        .op_out         (op_out),
        .alu_start      (alu_start),
        .Out_with_carry (Out_with_carry),
        .result_valid   (result_valid),
        .Letters        (Letters),
        .LED            (LED)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // which = {op, b, a}; one-cycle press followed by one released cycle.
    task automatic press(input logic [2:0] which, input logic [7:0] val);
        sw    = val;
        pb_a  = which[0];
        pb_b  = which[1];
        pb_op = which[2];
        tick(1);
        pb_a  = 1'b0;
        pb_b  = 1'b0;
        pb_op = 1'b0;
        tick(1);
    endtask

    function automatic start_exp_t mk_start(logic [1:0] op, logic [7:0] a, logic [7:0] b);
        start_exp_t e;
        e.op = op;
        e.a  = a;
        e.b  = b;
        return e;
    endfunction

    // Monitor: compare each start pulse and each SHOW entry against the queues.
    always @(negedge Clk) begin
        if (alu_start) begin
            start_count <= start_count + 1;
            check("start_not_consecutive", 32'(start_prev), 32'd0);
            if (start_q.size() == 0) begin
                check("start_unexpected", 32'(alu_start), 32'd0);
            end else begin
                check("start_op", 32'(op_out), 32'(start_q[0].op));
                check("start_a", 32'(A_out), 32'(start_q[0].a));
                check("start_b", 32'(B_out), 32'(start_q[0].b));
                start_q.delete(0);
            end
        end
        if (result_valid && !rv_prev) begin
            if (res_q.size() == 0) begin
                check("result_unexpected", 32'(result_valid), 32'd0);
            end else begin
                check("result_value", 32'(Out_with_carry), 32'(res_q[0]));
                res_q.delete(0);
            end
        end
        start_prev <= alu_start;
        rv_prev    <= result_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset      = 1'b1;
        pb_a       = 1'b0;
        pb_b       = 1'b0;
        pb_op      = 1'b0;
        sw         = 8'h5A;
        alu_done   = 1'b0;
        alu_result = '0;
        tick(2);
        check("rst_letters", 32'(Letters), 32'hF);
        check("rst_led", 32'(LED), 32'h5A);
        check("rst_a", 32'(A_out), 32'd0);
        check("rst_b", 32'(B_out), 32'd0);
        check("rst_op", 32'(op_out), 32'd0);
        check("rst_out", 32'(Out_with_carry), 32'd0);
        check("rst_start", 32'(alu_start), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        Reset = 1'b0;
        tick(1);

        // Normal flow.
        press(3'b001, 8'd200);
        check("nf_have_a", 32'(Letters), 32'hA);
        check("nf_a", 32'(A_out), 32'd200);
        check("nf_led_a", 32'(LED), 32'd200);
        press(3'b010, 8'd100);
        check("nf_have_b", 32'(Letters), 32'hB);
        check("nf_b", 32'(B_out), 32'd100);
        check("nf_led_b", 32'(LED), 32'd100);
        cnt0 = start_count;
        start_q.push_back(mk_start(2'd0, 8'd200, 8'd100));
        press(3'b100, 8'h00);
        check("nf_wait", 32'(Letters), 32'hD);
        check("nf_led_wait", 32'(LED), 32'h00);
        check("nf_one_start", 32'(start_count - cnt0), 32'd1);
        alu_done   = 1'b1;
        alu_result = 9'd300;
        res_q.push_back(9'd300);
        tick(1);
        alu_done = 1'b0;
        check("nf_show", 32'(Letters), 32'hC);
        check("nf_valid", 32'(result_valid), 32'd1);
        check("nf_led_show", 32'(LED), 32'h2C);
        check("nf_out", 32'(Out_with_carry), 32'd300);
        check("nf_a_kept", 32'(A_out), 32'd200);
        check("nf_b_kept", 32'(B_out), 32'd100);

        // alu_done outside WAIT is ignored.
        alu_done   = 1'b1;
        alu_result = 9'h005;
        tick(1);
        alu_done = 1'b0;
        check("stray_done_out", 32'(Out_with_carry), 32'd300);
        check("stray_done_state", 32'(Letters), 32'hC);

        // Re-execute from SHOW with a new opcode.
        start_q.push_back(mk_start(2'd1, 8'd200, 8'd100));
        press(3'b100, 8'h01);
        check("rx_op", 32'(op_out), 32'd1);
        check("rx_a", 32'(A_out), 32'd200);
        check("rx_b", 32'(B_out), 32'd100);
        check("rx_wait", 32'(Letters), 32'hD);
        alu_done   = 1'b1;
        alu_result = 9'h0FF;
        res_q.push_back(9'h0FF);
        tick(1);
        alu_done = 1'b0;
        check("rx_led", 32'(LED), 32'hFF);

        // Timeout: ERR exactly 16 cycles after WAIT entry (press returns 1 cycle in).
        press(3'b001, 8'h0F);
        press(3'b010, 8'hF0);
        start_q.push_back(mk_start(2'd2, 8'h0F, 8'hF0));
        press(3'b100, 8'h02);
        for (int i = 0; i < 15; i++) begin
            check("to_still_wait", 32'(Letters), 32'hD);
            tick(1);
        end
        check("to_err", 32'(Letters), 32'hE);
        check("to_led", 32'(LED), 32'hFF);
        check("to_out", 32'(Out_with_carry), 32'd0);
        check("to_valid", 32'(result_valid), 32'd0);
        press(3'b001, 8'h33);
        check("to_recover", 32'(Letters), 32'hA);
        check("to_recover_a", 32'(A_out), 32'h33);

        // alu_done on the last allowed WAIT cycle is accepted.
        press(3'b010, 8'h44);
        start_q.push_back(mk_start(2'd3, 8'h33, 8'h44));
        press(3'b100, 8'h03);
        tick(14);
        check("last_wait", 32'(Letters), 32'hD);
        alu_done   = 1'b1;
        alu_result = 9'h177;
        res_q.push_back(9'h177);
        tick(1);
        alu_done = 1'b0;
        check("last_show", 32'(Letters), 32'hC);
        check("last_out", 32'(Out_with_carry), 32'h177);
        check("last_led", 32'(LED), 32'h77);

        // Simultaneous presses in HAVE_B: execute wins, operands untouched.
        press(3'b001, 8'h11);
        press(3'b010, 8'h22);
        start_q.push_back(mk_start(2'd1, 8'h11, 8'h22));
        press(3'b111, 8'h01);
        check("sim_wait", 32'(Letters), 32'hD);
        check("sim_op", 32'(op_out), 32'd1);
        check("sim_a", 32'(A_out), 32'h11);
        check("sim_b", 32'(B_out), 32'h22);

        // Reset during WAIT aborts; a later alu_done is ignored.
        Reset = 1'b1;
        tick(1);
        Reset      = 1'b0;
        alu_done   = 1'b1;
        alu_result = 9'h1AB;
        tick(1);
        alu_done = 1'b0;
        tick(2);
        check("rw_idle", 32'(Letters), 32'hF);
        check("rw_out", 32'(Out_with_carry), 32'd0);
        check("rw_valid", 32'(result_valid), 32'd0);
        check("rw_a", 32'(A_out), 32'd0);

        // Button held through reset yields no press until re-pressed.
        pb_a  = 1'b1;
        sw    = 8'h66;
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
        tick(3);
        check("held_idle", 32'(Letters), 32'hF);
        check("held_a", 32'(A_out), 32'd0);
        pb_a = 1'b0;
        tick(1);
        press(3'b001, 8'h77);
        check("held_have_a", 32'(Letters), 32'hA);
        check("held_new_a", 32'(A_out), 32'h77);

        // HAVE_A with pb_a and pb_b together: pb_b wins.
        press(3'b011, 8'h99);
        check("pri_have_b", 32'(Letters), 32'hB);
        check("pri_b", 32'(B_out), 32'h99);
        check("pri_a_kept", 32'(A_out), 32'h77);

        tick(2);
        check("start_q_drained", 32'(start_q.size()), 32'd0);
        check("res_q_drained", 32'(res_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
